// File: rtl/ks_digit_serial_mul_if.sv
// Operand/result handshake bundle for the digit-serial carry-less multiplier.
// The producer side drives operands and out_ready; the multiplier drives the rest.
interface ks_digit_serial_mul_if #(
  parameter int N_DIG = 3
) ();
  localparam int W = 9 * N_DIG;
  localparam int P = 2 * W - 1;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [P-1:0] y;
  logic         busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, y, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, y, busy
  );
endinterface

// File: rtl/ks_digit_serial_mul.sv
// Digit-serial GF(2)[x] multiplier: one 9x9 Karatsuba core swept over all digit
// pairs, XOR-accumulating the 17-bit partial products into a full-width product.
module ks9 (
  input  logic [8:0]  a,
  input  logic [8:0]  b,
  output logic [16:0] p
);
  function automatic logic [8:0] clmul5(input logic [4:0] x, input logic [4:0] z);
    logic [8:0] r;
    r = 9'd0;
    for (int k = 0; k < 5; k++) begin
      if (z[k]) r = r ^ ({4'd0, x} << k);
      else      r = r;
    end
    return r;
  endfunction

  function automatic logic [6:0] clmul4(input logic [3:0] x, input logic [3:0] z);
    logic [6:0] r;
    r = 7'd0;
    for (int k = 0; k < 4; k++) begin
      if (z[k]) r = r ^ ({3'd0, x} << k);
      else      r = r;
    end
    return r;
  endfunction

  logic [8:0] p_ll_s;
  logic [6:0] p_hh_s;
  logic [8:0] p_mid_s;

  // Karatsuba split at bit 5: middle term recovered from (al^ah)(bl^bh) minus the outer terms.
  always_comb begin
    p_ll_s  = clmul5(a[4:0], b[4:0]);
    p_hh_s  = clmul4(a[8:5], b[8:5]);
    p_mid_s = clmul5(a[4:0] ^ {1'b0, a[8:5]}, b[4:0] ^ {1'b0, b[8:5]})
              ^ p_ll_s ^ {2'd0, p_hh_s};
    p       = {p_hh_s, 10'd0} ^ {3'd0, p_mid_s, 5'd0} ^ {8'd0, p_ll_s};
  end
endmodule

module ks_digit_serial_mul #(
  parameter int N_DIG = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  ks_digit_serial_mul_if.slave   bus
);
  localparam int W  = 9 * N_DIG;
  localparam int P  = 2 * W - 1;
  localparam int CW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam logic [CW-1:0] LAST_DIG = CW'(N_DIG - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_r;
  logic [W-1:0]  a_reg_r;
  logic [W-1:0]  b_reg_r;
  logic [P-1:0]  acc_r;
  logic [CW-1:0] i_r;
  logic [CW-1:0] j_r;
  logic          in_ready_r;
  logic          out_valid_r;
  logic          busy_r;

  logic [8:0]    a_dig_s;
  logic [8:0]    b_dig_s;
  logic [16:0]   pp_s;
  logic [P-1:0]  acc_next_s;

  // Select the current digit pair and fold its partial product in at weight 9(i+j).
  always_comb begin
    a_dig_s    = a_reg_r[9 * int'(i_r) +: 9];
    b_dig_s    = b_reg_r[9 * int'(j_r) +: 9];
    acc_next_s = acc_r ^ (P'(pp_s) << (9 * (int'(i_r) + int'(j_r))));
  end

  ks9 u_ks9 (
    .a (a_dig_s),
    .b (b_dig_s),
    .p (pp_s)
  );

  // Control FSM with operand, accumulator, counter and handshake-flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      a_reg_r     <= '0;
      b_reg_r     <= '0;
      acc_r       <= '0;
      i_r         <= '0;
      j_r         <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg_r    <= bus.a;
            b_reg_r    <= bus.b;
            acc_r      <= '0;
            i_r        <= '0;
            j_r        <= '0;
            state_r    <= MUL;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end
        end
        MUL: begin
          acc_r <= acc_next_s;
          if (j_r == LAST_DIG) begin
            j_r <= '0;
            if (i_r == LAST_DIG) begin
              i_r         <= '0;
              state_r     <= DONE;
              busy_r      <= 1'b0;
              out_valid_r <= 1'b1;
            end else begin
              i_r <= i_r + CW'(1);
            end
          end else begin
            j_r <= j_r + CW'(1);
          end
        end
        DONE: begin
          // acc is left intact so y holds the product until the next accept.
          if (bus.out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.y         = acc_r;
endmodule

// File: tb/tb_ks_digit_serial_mul.sv
// Scoreboard bench for ks_digit_serial_mul: directed vectors, backpressure,
// mid-operation reset and random operands against a bitwise polynomial model.
module tb_ks_digit_serial_mul;
  localparam int N_DIG = 3;
  localparam int W = 9 * N_DIG;
  localparam int P = 2 * W - 1;
  localparam int LAT = N_DIG * N_DIG;

  logic clk;
  logic rst;
  ks_digit_serial_mul_if #(.N_DIG(N_DIG)) bus ();

  ks_digit_serial_mul #(.N_DIG(N_DIG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [P-1:0] sb_q[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Schoolbook product over GF(2): x^i*b added (XOR) for every set coefficient of a.
  function automatic logic [P-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] z);
    logic [P-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++)
      for (int k = 0; k < W; k++)
        r[i + k] = r[i + k] ^ (x[i] & z[k]);
    return r;
  endfunction

  // Monitor: every completed handshake pops one expected product.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) chk("unexpected_output", 64'(bus.y), 64'hDEAD);
      else chk("product", 64'(bus.y), 64'(sb_q.pop_front()));
    end
  end

  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [P-1:0] exp_y);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("in_ready_timeout", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.a = av;
    bus.b = bv;
    sb_q.push_back(exp_y);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Accept, verify latency and busy, then the return to IDLE after handshake.
  task automatic run_one(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [P-1:0] exp_y);
    int lat;
    send(av, bv, exp_y);
    chk("busy_in_mul", 64'(bus.busy), 64'd1);
    chk("in_ready_in_mul", 64'(bus.in_ready), 64'd0);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(LAT));
    if (bus.out_ready) begin
      @(posedge clk); #1;
      chk("idle_after_hs", 64'({bus.in_ready, bus.out_valid}), 64'b10);
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [P-1:0] held;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.out_ready = 1'b1;
    #12;
    chk("reset_y", 64'(bus.y), 64'd0);
    chk("reset_flags", 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'b100);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_one(27'h0000001, 27'h7FFFFFF, 53'h00000007FFFFFF);
    run_one(27'h0000003, 27'h0000003, 53'h5);
    run_one(27'h4000000, 27'h4000000, 53'h10000000000000);
    run_one(27'h7FFFFFF, 27'h7FFFFFF, 53'h15555555555555);

    // Backpressure: result held, new operands ignored.
    bus.out_ready = 1'b0;
    ra = W'($urandom);
    rb = W'($urandom);
    held = ref_mul(ra, rb);
    run_one(ra, rb, held);
    for (int c = 0; c < 20; c++) begin
      bus.in_valid = c[0];
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      @(posedge clk); #1;
      chk("bp_y_stable", 64'(bus.y), 64'(held));
      chk("bp_flags", 64'({bus.in_ready, bus.out_valid}), 64'b01);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", 64'({bus.in_ready, bus.out_valid}), 64'b10);
    chk("bp_queue_drained", 64'(sb_q.size()), 64'd0);
    ra = W'($urandom);
    rb = W'($urandom);
    run_one(ra, rb, ref_mul(ra, rb));

    // Reset at MUL cycle 4 aborts the operation.
    send(W'($urandom), W'($urandom), '0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_flags", 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'b100);
    chk("abort_y", 64'(bus.y), 64'd0);
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    run_one(27'h5, 27'h3, 53'hF);

    for (int t = 0; t < 40; t++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (t % 8 == 0) ra = '0;
      run_one(ra, rb, ref_mul(ra, rb));
    end

    repeat (4) @(posedge clk);
    chk("final_queue_empty", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
